qdiv_iter: RTL

QDIV_ITER -- requirements
Module: qdiv_iter

---
 rtl/qdiv_iter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/qdiv_iter.sv
// Iterative restoring divider, BPC quotient bits per clock, optional two's-complement mode.
// Quotient truncates toward zero, remainder takes the dividend sign, B=0 gives q=all-ones, r=A.
module qdiv_iter #(
    parameter int unsigned DW        = 32,
    parameter int unsigned BPC       = 1,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [DW-1:0] A_i,
    input  logic [DW-1:0] B_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] quotient_o,
    output logic [DW-1:0] remainder_o,
    output logic          div_zero_o
);

    localparam int unsigned Iter = DW / BPC;
    localparam int unsigned CntW = $clog2(Iter + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StFix} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   a_raw_q, b_q, work_q, rem_q;
    logic            sgn_q, dz_q, q_neg_q, r_neg_q;
    logic [DW-1:0]   work_step, rem_step;
    logic [DW:0]     trial;
    logic            last_iter;

    assign ready_o   = (state_q == StIdle);
    assign last_iter = (cnt_q == CntW'(Iter - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: if (start_i) state_d = StLoad;
            StLoad: begin
                state_d = StCalc;
                cnt_d   = '0;
            end
            StCalc: begin
                if (last_iter) begin
                    state_d = StFix;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StFix:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // work_q shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        rem_step  = rem_q;
        work_step = work_q;
        trial     = '0;
        for (int i = 0; i < int'(BPC); i++) begin
            trial     = {rem_step, work_step[DW-1]};
            work_step = {work_step[DW-2:0], 1'b0};
            if (trial >= {1'b0, b_q}) begin
                trial        = trial - {1'b0, b_q};
                work_step[0] = 1'b1;
            end
            rem_step = trial[DW-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_raw_q     <= '0;
            b_q         <= '0;
            work_q      <= '0;
            rem_q       <= '0;
            sgn_q       <= 1'b0;
            dz_q        <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            valid_o     <= 1'b0;
            quotient_o  <= '0;
            remainder_o <= '0;
            div_zero_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        a_raw_q <= A_i;
                        b_q     <= B_i;
                        sgn_q   <= SIGNED_EN & signed_i;
                        dz_q    <= (B_i == '0);
                    end
                end
                StLoad: begin
                    work_q  <= (sgn_q && a_raw_q[DW-1]) ? -a_raw_q : a_raw_q;
                    b_q     <= (sgn_q && b_q[DW-1]) ? -b_q : b_q;
                    q_neg_q <= sgn_q & (a_raw_q[DW-1] ^ b_q[DW-1]);
                    r_neg_q <= sgn_q & a_raw_q[DW-1];
                    rem_q   <= '0;
                end
                StCalc: begin
                    work_q <= work_step;
                    rem_q  <= rem_step;
                end
                StFix: begin
                    valid_o    <= 1'b1;
                    div_zero_o <= dz_q;
                    if (dz_q) begin
                        quotient_o  <= '1;
                        remainder_o <= a_raw_q;
                    end else begin
                        quotient_o  <= q_neg_q ? -work_q : work_q;
                        remainder_o <= r_neg_q ? -rem_q : rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
